// File: rtl/mem_arbiter_pkg.sv
// Shared types, defaults and small helpers for the IF/DM single-port memory bus arbiter.
// Imported by mem_arbiter.
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W  = 32;
   localparam int ARB_DATA_W  = 32;
   localparam int ARB_TIMEOUT = 255;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_BUSY_IF = 3'd1,
      ARB_BUSY_DM = 3'd2,
      ARB_DONE_IF = 3'd3,
      ARB_DONE_DM = 3'd4
   } arb_state_e;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_IF   = 2'd1,
      GRANT_DM   = 2'd2
   } arb_grant_e;

   // On a tie the requester served last loses, so IF and DM alternate.
   function automatic arb_grant_e arb_pick(input logic if_req,
                                           input logic dm_req,
                                           input logic last_dm);
      arb_grant_e g;
      g = GRANT_NONE;
      if (if_req && dm_req) begin
         g = last_dm ? GRANT_IF : GRANT_DM;
      end else if (if_req) begin
         g = GRANT_IF;
      end else if (dm_req) begin
         g = GRANT_DM;
      end
      return g;
   endfunction

   function automatic arb_state_e arb_done_of(input arb_state_e busy);
      return (busy == ARB_BUSY_IF) ? ARB_DONE_IF : ARB_DONE_DM;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and data access (DM),
// running each access as a registered request/ack transaction with a timeout abort.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_pausereq_o,

   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_sel_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                dm_pausereq_o,

   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_sel_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ack_i,
   output logic                bus_err_o
);

   localparam int SEL_W = DATA_W / 8;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              last_dm_q, last_dm_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              bus_err_q, bus_err_d;
   arb_grant_e        grant;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ARB_IDLE;
         timer_q     <= '0;
         last_dm_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_sel_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         last_dm_q   <= last_dm_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_sel_q   <= mem_sel_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      last_dm_d   = last_dm_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_sel_d   = mem_sel_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      bus_err_d   = 1'b0;
      grant       = arb_pick(if_req_i, dm_req_i, last_dm_q);

      case (state_q)
         ARB_IDLE: begin
            case (grant)
               GRANT_IF: begin
                  state_d     = ARB_BUSY_IF;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_sel_d   = '1;
                  mem_addr_d  = if_addr_i;
                  mem_wdata_d = '0;
                  timer_d     = '0;
                  last_dm_d   = 1'b0;
               end
               GRANT_DM: begin
                  state_d     = ARB_BUSY_DM;
                  mem_req_d   = 1'b1;
                  mem_we_d    = dm_we_i;
                  mem_sel_d   = dm_sel_i;
                  mem_addr_d  = dm_addr_i;
                  mem_wdata_d = dm_wdata_i;
                  timer_d     = '0;
                  last_dm_d   = 1'b1;
               end
               default: ;
            endcase
         end

         // An ack on the final allowed cycle still completes the access normally.
         ARB_BUSY_IF, ARB_BUSY_DM: begin
            if (mem_ack_i) begin
               mem_req_d = 1'b0;
               state_d   = arb_done_of(state_q);
               if (state_q == ARB_BUSY_IF) begin
                  if_rdata_d = mem_rdata_i;
               end else if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
            end else if (timer_q == TMR_LAST) begin
               timer_d   = timer_q + 1'b1;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = arb_done_of(state_q);
               if (state_q == ARB_BUSY_IF) begin
                  if_rdata_d = '0;
               end else begin
                  dm_rdata_d = '0;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         ARB_DONE_IF, ARB_DONE_DM: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Pause drops only in the requester's own done cycle, when its rdata is valid.
   assign if_pausereq_o = if_req_i & (state_q != ARB_DONE_IF);
   assign dm_pausereq_o = dm_req_i & (state_q != ARB_DONE_DM);

   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_sel_o   = mem_sel_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts service
// order, bus fields, done cycles and read data; bus and requester monitors compare.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req_i = 1'b0;
   logic [AW-1:0] if_addr_i = '0;
   logic [DW-1:0] if_rdata_o;
   logic          if_pausereq_o;
   logic          dm_req_i = 1'b0;
   logic          dm_we_i = 1'b0;
   logic [3:0]    dm_sel_i = '0;
   logic [AW-1:0] dm_addr_i = '0;
   logic [DW-1:0] dm_wdata_i = '0;
   logic [DW-1:0] dm_rdata_o;
   logic          dm_pausereq_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [3:0]    mem_sel_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          mem_ack_i;
   logic          bus_err_o;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
      .if_pausereq_o(if_pausereq_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_pausereq_o(dm_pausereq_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          delay;
      bit          tmo;
   } bus_exp_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      int          cycle;
   } rsp_exp_t;

   bus_exp_t bus_q[$];
   rsp_exp_t if_q[$];
   rsp_exp_t dm_q[$];

   logic [31:0] ref_mem [16];
   logic [31:0] bus_mem [16];
   bit          m_last_dm  = 1'b0;
   logic [31:0] m_dm_rdata = '0;
   int          exp_errs   = 0;
   int          err_pulses = 0;

   bit          auto_bus  = 1'b1;
   logic        man_ack   = 1'b0;
   logic [31:0] man_rdata = '0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: one access occupies grant + busy cycles + done.
   function automatic int model_access(input bit is_dm, input int t, input logic [31:0] addr,
                                       input bit we, input logic [3:0] sel,
                                       input logic [31:0] wdata, input int delay, input bit tmo);
      bus_exp_t    b;
      rsp_exp_t    r;
      logic [3:0]  idx;
      int          busy;
      idx     = addr[5:2];
      busy    = tmo ? TMO : delay + 1;
      b.addr  = addr;
      b.we    = is_dm ? we : 1'b0;
      b.sel   = is_dm ? sel : 4'hF;
      b.wdata = wdata;
      b.delay = delay;
      b.tmo   = tmo;
      r.cycle = t + busy + 1;
      r.err   = tmo;
      if (tmo) begin
         r.rdata = '0;
      end else if (is_dm && we) begin
         for (int k = 0; k < 4; k++)
            if (sel[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
         r.rdata = m_dm_rdata;
      end else begin
         r.rdata = ref_mem[idx];
      end
      if (tmo) exp_errs++;
      if (is_dm) begin
         m_dm_rdata = r.rdata;
         dm_q.push_back(r);
      end else begin
         if_q.push_back(r);
      end
      bus_q.push_back(b);
      m_last_dm = is_dm;
      return r.cycle + 1;
   endfunction

   // Bus slave: checks each granted access and acks after its planned wait.
   initial begin
      bus_exp_t    e;
      int          n;
      logic [3:0]  idx;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (!auto_bus) begin
            mem_ack_i   = man_ack;
            mem_rdata_i = man_rdata;
         end else begin
            mem_ack_i = 1'b0;
            if (rst && mem_req_o) begin
               if (bus_q.size() == 0) begin
                  check32("bus_unexpected_req", 32'(mem_req_o), 32'd0);
               end else begin
                  e = bus_q.pop_front();
                  n = e.tmo ? TMO : e.delay + 1;
                  check32("bus_addr", mem_addr_o, e.addr);
                  check32("bus_we", 32'(mem_we_o), 32'(e.we));
                  check32("bus_sel", 32'(mem_sel_o), 32'(e.sel));
                  if (e.we) check32("bus_wdata", mem_wdata_o, e.wdata);
                  for (int i = 0; i < n; i++) begin
                     if (i > 0) begin
                        @(negedge clk);
                        check32("bus_req_held", 32'(mem_req_o), 32'd1);
                        check32("bus_addr_stable", mem_addr_o, e.addr);
                        check32("bus_sel_stable", 32'({mem_we_o, mem_sel_o}), 32'({e.we, e.sel}));
                     end
                     if (!e.tmo && i == e.delay) begin
                        mem_ack_i = 1'b1;
                        idx = mem_addr_o[5:2];
                        if (mem_we_o) begin
                           for (int k = 0; k < 4; k++)
                              if (mem_sel_o[k]) bus_mem[idx][8*k +: 8] = mem_wdata_o[8*k +: 8];
                           mem_rdata_i = $urandom;
                        end else begin
                           mem_rdata_i = bus_mem[idx];
                        end
                     end
                     @(posedge clk);
                     #1;
                     mem_ack_i   = 1'b0;
                     mem_rdata_i = $urandom;
                  end
                  check32("bus_req_drop", 32'(mem_req_o), 32'd0);
               end
            end
         end
      end
   end

   // Requester-side monitor: a done cycle is a held request whose pause has dropped.
   always @(negedge clk) begin
      rsp_exp_t e;
      if (bus_err_o) err_pulses++;
      if (rst && if_req_i && !if_pausereq_o) begin
         if (if_q.size() == 0) begin
            check32("if_unexpected_done", 32'(if_pausereq_o), 32'd1);
         end else begin
            e = if_q.pop_front();
            $display("[%0d] IF  done rdata=%h err=%0d", cyc, if_rdata_o, bus_err_o);
            check32("if_rdata", if_rdata_o, e.rdata);
            check32("if_err", 32'(bus_err_o), 32'(e.err));
            check32("if_done_cycle", 32'(cyc), 32'(e.cycle));
         end
      end
      if (rst && dm_req_i && !dm_pausereq_o) begin
         if (dm_q.size() == 0) begin
            check32("dm_unexpected_done", 32'(dm_pausereq_o), 32'd1);
         end else begin
            e = dm_q.pop_front();
            $display("[%0d] DM  done rdata=%h err=%0d", cyc, dm_rdata_o, bus_err_o);
            check32("dm_rdata", dm_rdata_o, e.rdata);
            check32("dm_err", 32'(bus_err_o), 32'(e.err));
            check32("dm_done_cycle", 32'(cyc), 32'(e.cycle));
         end
      end
   end

   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // Hold each request until its pause drops, then release it on that edge.
   task automatic wait_done();
      int budget;
      bit fin_if, fin_dm;
      budget = 200;
      while ((if_req_i || dm_req_i) && budget > 0) begin
         @(negedge clk);
         fin_if = if_req_i && !if_pausereq_o;
         fin_dm = dm_req_i && !dm_pausereq_o;
         @(posedge clk);
         #1;
         if (fin_if) if_req_i = 1'b0;
         if (fin_dm) dm_req_i = 1'b0;
         budget--;
      end
      if (budget == 0) begin
         bad++;
         total++;
         $display("FAIL wait_done: requests still pending got if=%0d dm=%0d want 0 0",
                  if_req_i, dm_req_i);
         finish_run();
      end
   endtask

   task automatic run_round(input bit do_if, input bit do_dm,
                            input logic [31:0] ia, input logic [31:0] da, input bit dwe,
                            input logic [3:0] dsel, input logic [31:0] dwd,
                            input int idly, input bit itmo, input int ddly, input bit dtmo);
      int t;
      if_addr_i  = ia;
      dm_addr_i  = da;
      dm_we_i    = dwe;
      dm_sel_i   = dsel;
      dm_wdata_i = dwd;
      if_req_i   = do_if;
      dm_req_i   = do_dm;
      t = cyc;
      if (do_if && do_dm) begin
         if (m_last_dm) begin
            t = model_access(1'b0, t, ia, 1'b0, 4'hF, 32'd0, idly, itmo);
            void'(model_access(1'b1, t, da, dwe, dsel, dwd, ddly, dtmo));
         end else begin
            t = model_access(1'b1, t, da, dwe, dsel, dwd, ddly, dtmo);
            void'(model_access(1'b0, t, ia, 1'b0, 4'hF, 32'd0, idly, itmo));
         end
      end else if (do_if) begin
         void'(model_access(1'b0, t, ia, 1'b0, 4'hF, 32'd0, idly, itmo));
      end else if (do_dm) begin
         void'(model_access(1'b1, t, da, dwe, dsel, dwd, ddly, dtmo));
      end
      wait_done();
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      return {26'd0, w, 2'b00};
   endfunction

   task automatic pick_delay(output int d, output bit tmo);
      int r;
      r   = $urandom_range(0, 9);
      tmo = (r >= 8);
      d   = r % TMO;
   endtask

   initial begin
      int  t, kind, gap, idly, ddly;
      bit  itmo, dtmo;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         bus_mem[i] = ref_mem[i];
      end
      ref_mem[1] = 32'h3401_1100;
      bus_mem[1] = 32'h3401_1100;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check32("reset_mem_req", 32'(mem_req_o), 32'd0);
      check32("reset_bus_err", 32'(bus_err_o), 32'd0);
      check32("reset_if_rdata", if_rdata_o, 32'd0);
      check32("reset_dm_rdata", dm_rdata_o, 32'd0);
      check32("reset_mem_addr", mem_addr_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed: IF alone with immediate ack, first tie, repeated tie, store, timeout, coincide.
      run_round(1, 0, 32'h4, 32'h0, 0, 4'hF, 32'h0, 0, 0, 0, 0);
      run_round(1, 1, 32'h8, 32'h100, 0, 4'hF, 32'h0, 1, 0, 0, 0);
      run_round(1, 1, 32'hC, 32'h10, 0, 4'hF, 32'h0, 0, 0, 2, 0);
      run_round(0, 1, 32'h0, 32'h20, 1, 4'b0011, 32'hDEAD_BEEF, 0, 0, 3, 0);
      run_round(0, 1, 32'h0, 32'h20, 0, 4'hF, 32'h0, 0, 0, 0, 0);
      run_round(0, 1, 32'h0, 32'h24, 0, 4'hF, 32'h0, 0, 0, 0, 1);
      run_round(0, 1, 32'h0, 32'h28, 0, 4'hF, 32'h0, 0, 0, TMO - 1, 0);
      run_round(1, 0, 32'h2C, 32'h0, 0, 4'hF, 32'h0, 0, 1, 0, 0);

      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 2);
         pick_delay(idly, itmo);
         pick_delay(ddly, dtmo);
         run_round(kind != 1, kind != 0, rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)),
                   4'($urandom_range(1, 15)), $urandom, idly, itmo, ddly, dtmo);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end

      // IF request withdrawn while busy: the bus cycle still runs to completion.
      if_addr_i = 32'h30;
      if_req_i  = 1'b1;
      t = model_access(1'b0, cyc, 32'h30, 1'b0, 4'hF, 32'd0, 2, 1'b0);
      void'(if_q.pop_back());
      @(posedge clk);
      #1;
      if_req_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Reset during BUSY_DM with a late ack; the held request must be granted again.
      auto_bus   = 1'b0;
      dm_addr_i  = 32'h14;
      dm_we_i    = 1'b0;
      dm_sel_i   = 4'hF;
      dm_req_i   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check32("rst_test_busy_req", 32'(mem_req_o), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b1;
      man_ack   = 1'b1;
      man_rdata = 32'hBAD0_BAD0;
      m_last_dm  = 1'b0;
      m_dm_rdata = '0;
      void'(model_access(1'b1, cyc, 32'h14, 1'b0, 4'hF, 32'd0, 1, 1'b0));
      @(negedge clk);
      check32("rst_mem_req", 32'(mem_req_o), 32'd0);
      check32("rst_mem_we_sel", 32'({mem_we_o, mem_sel_o}), 32'd0);
      check32("rst_mem_addr", mem_addr_o, 32'd0);
      check32("rst_mem_wdata", mem_wdata_o, 32'd0);
      check32("rst_rdata", if_rdata_o | dm_rdata_o, 32'd0);
      check32("rst_bus_err", 32'(bus_err_o), 32'd0);
      check32("rst_dm_pause", 32'(dm_pausereq_o), 32'd1);
      @(posedge clk);
      #1;
      man_ack  = 1'b0;
      auto_bus = 1'b1;
      wait_done();

      run_round(1, 1, 32'h18, 32'h1C, 0, 4'hF, 32'h0, 0, 0, 1, 0);
      repeat (3) @(posedge clk);
      #1;

      check32("if_q_drained", 32'(if_q.size()), 32'd0);
      check32("dm_q_drained", 32'(dm_q.size()), 32'd0);
      check32("bus_q_drained", 32'(bus_q.size()), 32'd0);
      check32("bus_err_pulses", 32'(err_pulses), 32'(exp_errs));
      finish_run();
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "global timeout");
   end

endmodule
